// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with Mealy match flag.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int FILL_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [MAX_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;

    logic [LEN_W-1:0]   eff_len;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;
    logic               accept;

    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        eff_len = len_r;
        if (int'(len_r) > MAX_LEN)
            eff_len = LEN_W'(MAX_LEN);

        window = {hist, x};

        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(eff_len));

        // Enough accepted bits are in hist to complete the pattern with the live bit.
        fill_ok = (int'(fill) + 1 >= int'(eff_len));
        accept  = x_valid & ~cfg_load;

        z = accept & ~reset & (eff_len != '0) & fill_ok &
            ((window & mask) == (pat_r & mask));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= 1'b0;
            hist  <= '0;
            fill  <= '0;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
        end else if (x_valid) begin
            hist <= window[MAX_LEN-2:0];
            if (z && !ovl_r)
                fill <= '0;
            else if (fill != FILL_W'(MAX_LEN))
                fill <= fill + 1'b1;
        end
    end

`ifdef SEQ_DET_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            match_cnt <= '0;
        else if (z && (match_cnt != '1))
            match_cnt <= match_cnt + 1'b1;
    end
`else
    assign match_cnt = '0;
`endif

endmodule
